// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester arbiter/sequencer for an 8x8 single-port memory
// Optional: define ARB_FIXED_PRIO_EN for fixed priority (requester 0 always wins contention).
module mem_arbiter #(
  parameter int AW       = 3,
  parameter int DW       = 8,
  parameter int READ_LAT = 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] adr0,
  input  logic [DW-1:0] wdata0,
  output logic          ack0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] adr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,
  output logic [DW-1:0] rdata,
  output logic          mem_rw,
  output logic [AW-1:0] mem_adr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam int CW = 3;

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  state_t          state_q, state_d;
  logic            grant_d;
  logic            gnt_q;
  logic            we_q;
  logic [CW-1:0]   cnt_q;
  logic            any_req;
  logic            sel_we;
  logic [AW-1:0]   sel_adr;
  logic [DW-1:0]   sel_wdata;

`ifndef ARB_FIXED_PRIO_EN
  logic            rr_ptr;
`endif

  assign any_req   = req0 | req1;
  assign busy      = (state_q != IDLE);
  assign sel_we    = grant_d ? we1    : we0;
  assign sel_adr   = grant_d ? adr1   : adr0;
  assign sel_wdata = grant_d ? wdata1 : wdata0;

  // Winner selection only matters in IDLE; a lone requester always wins.
  always_comb begin
    grant_d = 1'b0;
`ifdef ARB_FIXED_PRIO_EN
    grant_d = ~req0;
`else
    if (req0 && req1) grant_d = rr_ptr;
    else              grant_d = req1;
`endif
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = ACCESS;
      ACCESS:  state_d = we_q ? RESP : WAIT;
      WAIT:    if (cnt_q == CW'(1)) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Memory pins are registered so they only move on clock edges; mem_rw idles high (read).
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      gnt_q     <= 1'b0;
      we_q      <= 1'b0;
      cnt_q     <= '0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      rdata     <= '0;
      mem_rw    <= 1'b1;
      mem_adr   <= '0;
      mem_wdata <= '0;
`ifndef ARB_FIXED_PRIO_EN
      rr_ptr    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            gnt_q     <= grant_d;
            we_q      <= sel_we;
            mem_adr   <= sel_adr;
            mem_wdata <= sel_wdata;
            mem_rw    <= ~sel_we;
          end
        end
        ACCESS: begin
          mem_rw <= 1'b1;
          if (we_q) begin
            ack0 <= ~gnt_q;
            ack1 <= gnt_q;
          end else begin
            cnt_q <= CW'(READ_LAT);
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            rdata <= mem_rdata;
            ack0  <= ~gnt_q;
            ack1  <= gnt_q;
          end
        end
        RESP: begin
          ack0 <= 1'b0;
          ack1 <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
          rr_ptr <= ~gnt_q;
`endif
        end
        default: begin
          ack0   <= 1'b0;
          ack1   <= 1'b0;
          mem_rw <= 1'b1;
        end
      endcase
    end
  end

endmodule
